i2s_receiver: RTL and testbench
===============================

// Module: i2s_receiver
// PURPOSE
//  Receive end of the I2S link driven by the PSG audio system. Deserialises i2s_sclk/i2s_lrclk/i2s_data
//  (Philips I2S, MSB first, slave mode) into signed stereo sample pairs.
//  Buffers the pairs in a small FWFT FIFO with a valid/ready handshake toward the mixer or capture logic.
//  Used for audio loopback checking and external line-in.
// PARAMETERS
//  SAMPLE_BITS  16  bits captured per channel (MSB-aligned); extra slot bits are ignored
//  FIFO_DEPTH   4   stereo pairs buffered; must be a power of 2, >= 2
//  SYNC_STAGES  2   flop stages on each I2S input; must be >= 2
// PORTS
//  clk          in   1            system clock; must be >= 4x i2s_sclk frequency
//  reset_n      in   1            asynchronous active-low reset
//  i2s_sclk     in   1            bit clock, asynchronous to clk
//  i2s_lrclk    in   1            word select: 0 = left, 1 = right
//  i2s_data     in   1            serial data, valid on i2s_sclk rising edge
//  smp_left     out  SAMPLE_BITS  signed left sample at FIFO head
//  smp_right    out  SAMPLE_BITS  signed right sample at FIFO head
//  smp_valid    out  1            FIFO not empty
//  smp_ready    in   1            consumer accepts head when smp_valid && smp_ready
//  err_clr      in   1            single-cycle pulse; clears overflow and frame_err
//  overflow     out  1            sticky: a completed pair was dropped because the FIFO was full
//  frame_err    out  1            sticky: a channel slot was shorter than SAMPLE_BITS bits
// BEHAVIOUR
//  Reset (async assert, sync deassert via clk): FIFO empty, all outputs 0, bit counter 0, left_hold invalid, locked=0.
//  Input path:
//   - sclk/lrclk/data each pass through SYNC_STAGES flops.
//   - An sclk rising edge is detected when sync_sclk goes 0->1 vs. its 1-cycle-delayed copy.
//   - All further logic advances only on detected edges; ws/bit are sampled on that same cycle.
//  Word framing, per edge:
//   - Boundary: ws != ws_prev. The bit on that edge is the LSB slot of the old channel.
//   - Every edge: if cnt < SAMPLE_BITS, word[SAMPLE_BITS-1-cnt] <= bit. cnt increments, saturating at SAMPLE_BITS.
//   - At a boundary: finish the old word (bit included), then clear word to 0, set cnt=0, ws_prev <= ws.
//   - A finished word with fewer than SAMPLE_BITS bits keeps zero-padded LSBs and sets frame_err.
//  Lock:
//   - locked=0 until the first boundary after reset. No word is finished before lock.
//   - Short-word check is skipped for the first finished word.
//  Pairing:
//   - Finished left word -> left_hold, marked valid.
//   - Finished right word with left_hold valid -> push {left_hold, right} into FIFO, clear left_hold valid.
//   - Finished right word with left_hold invalid -> discarded silently.
//  FIFO (FWFT, FIFO_DEPTH entries):
//   - Pop when smp_valid && smp_ready. The head updates on the next cycle.
//   - Push while full and not popping: pair dropped, overflow <= 1, FIFO contents unchanged.
//   - Push and pop in the same cycle while full: both happen, no overflow.
//   - Push and pop in the same cycle while empty: push only (no valid head to pop).
//   - smp_left/smp_right are 0 when empty.
//  Sticky flags: err_clr clears both. If a set event coincides with err_clr, set wins.
//  Latency:
//   - smp_valid rises SYNC_STAGES+2 clk cycles after the first clk edge that samples the sclk rise
//     carrying the right-channel LSB slot (FIFO initially empty).
//  Reset mid-frame: everything is flushed. Reception resumes cleanly at the next lrclk boundary; the partial frame is lost.
// TESTING
//  T1 SAMPLE_BITS=16, 32-bit slots, clk=8x sclk.
//     Send L=16'h8001, R=16'h7FFE, then one more boundary.
//     -> one pair L=8001 R=7FFE, smp_valid at specified latency, no flags.
//  T2 24-bit slots, L=24'h123456, R=24'hABCDEF.
//     -> L=1234, R=ABCD; extra bits ignored; frame_err stays 0.
//  T3 smp_ready=0, send 5 frames (L=n, R=~n).
//     -> pairs 0..3 held in order; overflow=1 after frame 4.
//     -> err_clr pulse gives overflow=0; draining yields exactly 4 pairs.
//  T4 Assert reset_n=0 mid left word, release, then start stream mid right slot.
//     -> no output until first full L+R after a boundary; first pair correct.
//  T5 Slot of 10 bits with data 10'h3FF.
//     -> word FFC0 (zero-padded LSBs), frame_err=1.
//     -> err_clr in the same cycle as a new short word leaves frame_err=1.
//  T6 FIFO full with continuous stream and smp_ready held 1.
//     -> simultaneous push/pop; no overflow, no lost or duplicated pairs over 64 frames.

Source files
------------

// File: rtl/i2s_receiver_if.sv
// Sample stream from the I2S receiver to its consumer (mixer or capture logic).
//   smp_left/smp_right : signed stereo pair at the FIFO head (0 when empty)
//   smp_valid          : a pair is available
//   smp_ready          : consumer takes the head pair when smp_valid && smp_ready
// master = receiver side, slave = consumer side.
interface i2s_receiver_if #(
    parameter int SAMPLE_BITS = 16
);
    logic signed [SAMPLE_BITS-1:0] smp_left;
    logic signed [SAMPLE_BITS-1:0] smp_right;
    logic                          smp_valid;
    logic                          smp_ready;

    modport master (
        output smp_left,
        output smp_right,
        output smp_valid,
        input  smp_ready
    );

    modport slave (
        input  smp_left,
        input  smp_right,
        input  smp_valid,
        output smp_ready
    );
endinterface

// File: rtl/i2s_receiver.sv
// Philips I2S slave receiver. Oversamples i2s_sclk/i2s_lrclk/i2s_data in the clk
// domain, rebuilds MSB-first channel words, pairs left+right and buffers the pairs
// in a first-word-fall-through FIFO.
//
// Ports:
//   clk        system clock, at least 4x the I2S bit clock
//   reset_n    asynchronous active-low reset (released synchronously inside)
//   i2s_sclk   bit clock, asynchronous to clk
//   i2s_lrclk  word select, 0 = left, 1 = right
//   i2s_data   serial data, sampled on i2s_sclk rising edges
//   err_clr    one-cycle pulse clearing overflow and frame_err
//   overflow   sticky, a complete pair was dropped on a full FIFO
//   frame_err  sticky, a channel slot was shorter than SAMPLE_BITS
//   smp        sample stream (i2s_receiver_if.master)
//
// Framing FSM:
//   state    | meaning
//   ST_HUNT  | waiting for the first lrclk boundary, nothing is emitted
//   ST_FIRST | locked; the next finished word may be partial, no short check
//   ST_RUN   | normal reception, short words flag frame_err
module i2s_receiver #(
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i2s_sclk,
    input  logic               i2s_lrclk,
    input  logic               i2s_data,
    input  logic               err_clr,
    output logic               overflow,
    output logic               frame_err,
    i2s_receiver_if.master     smp
);
    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0]          SB_C    = CW'(SAMPLE_BITS);
    localparam logic [SAMPLE_BITS-1:0] MSB_ONE = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    typedef enum logic [1:0] {ST_HUNT, ST_FIRST, ST_RUN} frame_state_t;

    // reset: asserted asynchronously, released on clk
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // input synchronisers; all three lines see the same delay
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   sclk_d;
    logic                   sclk_rise;
    logic                   ws_now;
    logic                   bit_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ws_sync   <= '0;
            dat_sync  <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i2s_sclk};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i2s_lrclk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], i2s_data};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign ws_now    = ws_sync[SYNC_STAGES-1];
    assign bit_now   = dat_sync[SYNC_STAGES-1];

    // word assembly
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic [SAMPLE_BITS-1:0] word;
    logic [SAMPLE_BITS-1:0] word_next;
    logic                   ws_prev;
    logic                   room;
    logic                   boundary;
    logic                   short_word;

    assign room       = cnt < SB_C;
    assign cnt_next   = room ? cnt + CW'(1) : cnt;
    // word is cleared at every boundary, so OR-ing in the new bit is enough
    assign word_next  = (room && bit_now) ? (word | (MSB_ONE >> cnt)) : word;
    assign boundary   = ws_now != ws_prev;
    assign short_word = cnt_next < SB_C;

    frame_state_t state_q;
    frame_state_t state_d;
    logic         finish;
    logic         check_short;
    logic         ferr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        finish      = 1'b0;
        check_short = 1'b0;
        if (sclk_rise && boundary) begin
            case (state_q)
                ST_HUNT: state_d = ST_FIRST;
                ST_FIRST: begin
                    finish  = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    finish      = 1'b1;
                    check_short = 1'b1;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    assign ferr_set = finish & check_short & short_word;

    logic                   fin_vld;
    logic                   fin_right;
    logic [SAMPLE_BITS-1:0] fin_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            word      <= '0;
            ws_prev   <= 1'b0;
            fin_vld   <= 1'b0;
            fin_right <= 1'b0;
            fin_word  <= '0;
            frame_err <= 1'b0;
        end else begin
            fin_vld <= 1'b0;
            if (sclk_rise) begin
                if (boundary) begin
                    // the bit on the boundary edge is the old channel's LSB slot
                    cnt       <= '0;
                    word      <= '0;
                    ws_prev   <= ws_now;
                    fin_vld   <= finish;
                    fin_right <= ws_prev;
                    fin_word  <= word_next;
                end else begin
                    cnt  <= cnt_next;
                    word <= word_next;
                end
            end
            frame_err <= ferr_set | (frame_err & ~err_clr);
        end
    end

    // left/right pairing
    logic [SAMPLE_BITS-1:0] left_hold;
    logic                   left_vld;
    logic                   push_req;
    logic [SAMPLE_BITS-1:0] push_left;
    logic [SAMPLE_BITS-1:0] push_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_hold  <= '0;
            left_vld   <= 1'b0;
            push_req   <= 1'b0;
            push_left  <= '0;
            push_right <= '0;
        end else begin
            push_req <= 1'b0;
            if (fin_vld) begin
                if (!fin_right) begin
                    left_hold <= fin_word;
                    left_vld  <= 1'b1;
                end else if (left_vld) begin
                    push_req   <= 1'b1;
                    push_left  <= left_hold;
                    push_right <= fin_word;
                    left_vld   <= 1'b0;
                end
            end
        end
    end

    // FWFT FIFO
    logic [2*SAMPLE_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [NW-1:0]            count;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     pop;
    logic                     do_push;
    logic                     ovf_set;
    logic [2*SAMPLE_BITS-1:0] head;

    assign fifo_empty = count == '0;
    assign fifo_full  = count == NW'(FIFO_DEPTH);
    assign pop        = ~fifo_empty & smp.smp_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign do_push    = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_left, push_right};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count    <= count + NW'(do_push) - NW'(pop);
            overflow <= ovf_set | (overflow & ~err_clr);
        end
    end

    assign head          = mem[rd_ptr];
    assign smp.smp_valid = ~fifo_empty;
    assign smp.smp_left  = fifo_empty ? '0 : head[2*SAMPLE_BITS-1:SAMPLE_BITS];
    assign smp.smp_right = fifo_empty ? '0 : head[SAMPLE_BITS-1:0];
endmodule

// File: tb/tb_i2s_receiver.sv
module tb_i2s_receiver;
    localparam int SB    = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = 4;   // clk cycles per sclk half period (8x oversampling)

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic i2s_sclk  = 1'b0;
    logic i2s_lrclk = 1'b0;
    logic i2s_data  = 1'b0;
    logic err_clr   = 1'b0;
    logic overflow;
    logic frame_err;

    i2s_receiver_if #(.SAMPLE_BITS(SB)) smp_if ();

    i2s_receiver #(
        .SAMPLE_BITS(SB),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i2s_sclk (i2s_sclk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_data (i2s_data),
        .err_clr  (err_clr),
        .overflow (overflow),
        .frame_err(frame_err),
        .smp      (smp_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // stream description: one entry per lrclk slot
    int          s_ws[$];
    int          s_len[$];
    logic [31:0] s_val[$];

    logic [31:0] exp_q[$];
    logic        exp_ferr;
    int          exp_pairs;
    logic [31:0] obs_q[$];

    // every accepted handshake, sampled mid-cycle
    always @(negedge clk) begin
        if (smp_if.smp_valid && smp_if.smp_ready)
            obs_q.push_back({smp_if.smp_left, smp_if.smp_right});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic add_slot(input int ws, input int len, input logic [31:0] val);
        s_ws.push_back(ws);
        s_len.push_back(len);
        s_val.push_back(val);
    endtask

    task automatic clear_slots();
        s_ws.delete();
        s_len.delete();
        s_val.delete();
    endtask

    // MSB-aligned capture: long slots are truncated, short slots zero-padded
    function automatic logic [SB-1:0] word_of(input int len, input logic [31:0] val);
        if (len >= SB) return SB'(val >> (len - SB));
        return SB'(val << (SB - len));
    endfunction

    // Slot 0 always starts with lrclk=1 so it locks on its first edge; every slot
    // except the last is closed by the following boundary. The first closed slot is
    // a right word with no left partner and is never length-checked.
    task automatic build_model();
        logic [SB-1:0] hold;
        logic [SB-1:0] w;
        bit            hv;
        hv = 0;
        hold = '0;
        exp_q.delete();
        exp_ferr = 1'b0;
        for (int k = 0; k < s_ws.size() - 1; k++) begin
            w = word_of(s_len[k], s_val[k]);
            if (k > 0 && s_len[k] < SB) exp_ferr = 1'b1;
            if (s_ws[k] == 0) begin
                hold = w;
                hv   = 1;
            end else if (hv) begin
                exp_q.push_back({hold, w});
                hv = 0;
            end
        end
        exp_pairs = exp_q.size();
    endtask

    task automatic sclk_cycle(input bit ws, input bit b);
        i2s_sclk  = 1'b0;
        i2s_lrclk = ws;
        i2s_data  = b;
        repeat (HALF) @(posedge clk);
        #1 i2s_sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    // Same as sclk_cycle, but tracks the clk edges after the sclk rise (E0 = first
    // clk edge that samples it) to probe cycle-exact behaviour.
    // mode 1: valid still low after E3, high after E4
    // mode 2: raise smp_ready after E3
    // mode 3: err_clr during the cycle ending at E2, frame_err must stay set
    task automatic marked_cycle(input bit ws, input bit b, input int mode);
        i2s_sclk  = 1'b0;
        i2s_lrclk = ws;
        i2s_data  = b;
        repeat (HALF) @(posedge clk);
        #1 i2s_sclk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (mode == 3) begin
            chk("t5_ferr_before", frame_err, 1);
            err_clr = 1'b1;
        end
        @(posedge clk);
        #1;
        if (mode == 3) begin
            err_clr = 1'b0;
            chk("t5_set_beats_clr", frame_err, 1);
        end
        @(posedge clk);
        #1;
        if (mode == 1) chk("t1_latency_early", smp_if.smp_valid, 0);
        if (mode == 2) smp_if.smp_ready = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 1) chk("t1_latency_valid", smp_if.smp_valid, 1);
    endtask

    // Philips timing: each edge carries the bit of the previous bit slot
    task automatic run_stream(input int mark_slot, input int mode);
        bit          prev;
        bit          ws_b;
        logic [31:0] v;
        prev = 1'b0;
        for (int k = 0; k < s_ws.size(); k++) begin
            v    = s_val[k];
            ws_b = (s_ws[k] != 0);
            for (int i = 0; i < s_len[k]; i++) begin
                if (k == mark_slot && i == 0) marked_cycle(ws_b, prev, mode);
                else                          sclk_cycle(ws_b, prev);
                prev = v[s_len[k] - 1 - i];
            end
        end
        i2s_sclk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        i2s_sclk  = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_data  = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        obs_q.delete();
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    task automatic drain_and_compare(input string tag);
        smp_if.smp_ready = 1'b1;
        repeat (3 * DEPTH + 8) @(posedge clk);
        #1 smp_if.smp_ready = 1'b0;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) chk($sformatf("%s_pair%0d", tag, i), obs_q[i], exp_q[i]);
        end
        chk({tag, "_empty"}, smp_if.smp_valid, 0);
    endtask

    initial begin
        smp_if.smp_ready = 1'b0;

        // reset state
        do_reset();
        chk("rst_valid", smp_if.smp_valid, 0);
        chk("rst_head", {smp_if.smp_left, smp_if.smp_right}, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);

        // T1: 32-bit slots, cycle-exact latency of the first pair
        clear_slots();
        add_slot(1, 4, 0);
        add_slot(0, 32, {16'h8001, 16'($urandom)});
        add_slot(1, 32, {16'h7FFE, 16'($urandom)});
        add_slot(0, 2, 0);
        build_model();
        chk("t1_model", exp_q[0], 32'h8001_7FFE);
        run_stream(3, 1);
        chk("t1_head", {smp_if.smp_left, smp_if.smp_right}, exp_q[0]);
        chk("t1_overflow", overflow, 0);
        chk("t1_frame_err", frame_err, exp_ferr);
        drain_and_compare("t1");

        // T2: 24-bit slots, extra bits ignored
        do_reset();
        clear_slots();
        add_slot(1, 4, 0);
        add_slot(0, 24, 32'h0012_3456);
        add_slot(1, 24, 32'h00AB_CDEF);
        add_slot(0, 2, 0);
        build_model();
        smp_if.smp_ready = 1'b1;
        run_stream(-1, 0);
        chk("t2_frame_err", frame_err, exp_ferr);
        drain_and_compare("t2");

        // T3: five frames into a stalled FIFO
        do_reset();
        clear_slots();
        add_slot(1, 4, 0);
        for (int n = 0; n < 5; n++) begin
            add_slot(0, 16, 32'(n));
            add_slot(1, 16, {16'h0, ~(16'(n))});
        end
        add_slot(0, 2, 0);
        build_model();
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        run_stream(-1, 0);
        chk("t3_overflow", overflow, (exp_pairs > DEPTH) ? 1 : 0);
        chk("t3_frame_err", frame_err, exp_ferr);
        pulse_err_clr();
        chk("t3_overflow_clr", overflow, 0);
        drain_and_compare("t3");

        // T4: reset in the middle of a left word, resume mid right slot
        do_reset();
        clear_slots();
        add_slot(1, 4, 0);
        add_slot(0, 16, $urandom & 32'hFFFF);
        add_slot(1, 16, $urandom & 32'hFFFF);
        add_slot(0, 7, $urandom & 32'h7F);
        run_stream(-1, 0);
        chk("t4_pair_before_reset", smp_if.smp_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("t4_reset_valid", smp_if.smp_valid, 0);
        chk("t4_reset_head", {smp_if.smp_left, smp_if.smp_right}, 0);
        do_reset();
        clear_slots();
        add_slot(1, 7, $urandom & 32'h7F);
        add_slot(0, 16, $urandom & 32'hFFFF);
        add_slot(1, 16, $urandom & 32'hFFFF);
        add_slot(0, 2, 0);
        build_model();
        smp_if.smp_ready = 1'b1;
        run_stream(-1, 0);
        chk("t4_frame_err", frame_err, exp_ferr);
        drain_and_compare("t4");

        // T5: 10-bit slots, err_clr colliding with a new short word
        do_reset();
        clear_slots();
        add_slot(1, 4, 0);
        add_slot(0, 10, 32'h3FF);
        add_slot(1, 10, 32'h3FF);
        add_slot(0, 10, 32'h3FF);
        add_slot(1, 16, $urandom & 32'hFFFF);
        add_slot(0, 2, 0);
        build_model();
        chk("t5_model", exp_q[0], 32'hFFC0_FFC0);
        smp_if.smp_ready = 1'b1;
        run_stream(4, 3);
        chk("t5_frame_err", frame_err, exp_ferr);
        drain_and_compare("t5");
        pulse_err_clr();
        chk("t5_frame_err_clr", frame_err, 0);

        // T6: fill the FIFO, then pop exactly as the next pair is pushed; 64 frames
        do_reset();
        clear_slots();
        add_slot(1, 4, 0);
        for (int n = 0; n < 64; n++) begin
            add_slot(0, 16, $urandom & 32'hFFFF);
            add_slot(1, 16, $urandom & 32'hFFFF);
        end
        add_slot(0, 2, 0);
        build_model();
        run_stream(1 + 2 * DEPTH + 2, 2);
        chk("t6_overflow", overflow, 0);
        chk("t6_frame_err", frame_err, exp_ferr);
        drain_and_compare("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
